boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// external memory as big-endian 32-bit words through a command FIFO and a
// write-data FIFO. boot_done gates instruction fetch; boot_error flags an
// aborted load.
//
// FIFO handshake: a push strobe (mem_wr_en / mem_cmd_en) is a registered
// one-cycle pulse. It is raised only when the matching full flag was low
// on the clock edge that produced it. While full is high the push state
// holds and no strobe is raised. Data, mask and address are loaded before
// their strobe rises and are not changed while it is high. Each word is
// pushed as one write-data entry followed by one write command.
module boot_loader #(
    parameter logic [29:0] BASE_ADDR = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    input  logic        mem_wr_full,
    input  logic        mem_wr_error,
    output logic        boot_done,
    output logic        boot_error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        LEN_HI   = 3'd0,
        LEN_LO   = 3'd1,
        DATA     = 3'd2,
        PUSH_WR  = 3'd3,
        PUSH_CMD = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_d;

    logic [15:0] len;       // payload length N
    logic [15:0] k;         // payload bytes received so far
    logic [13:0] w;         // words fully pushed so far
    logic [31:0] word_buf;  // word being assembled

    logic        take_byte;
    logic        issue_wr;
    logic        issue_cmd;
    logic [15:0] k_inc;
    logic        word_end;
    logic [31:0] buf_next;
    logic [3:0]  mask_next;

    // Every command is a single-beat write.
    assign mem_cmd_instr = 3'b000;
    assign mem_cmd_bl    = 6'd0;
    assign state_dbg     = state;

    assign k_inc    = k + 16'd1;
    // A word closes on its fourth byte or on the final payload byte.
    assign word_end = (k[1:0] == 2'd3) || (k_inc == len);

    // Merge the incoming byte into its big-endian lane and derive the mask
    // for a word that closes at this byte (lanes not yet filled are masked).
    always_comb begin
        buf_next  = word_buf;
        mask_next = 4'b0000;
        case (k[1:0])
            2'd0: begin
                buf_next[31:24] = rx_data;
                mask_next       = 4'b0111;
            end
            2'd1: begin
                buf_next[23:16] = rx_data;
                mask_next       = 4'b0011;
            end
            2'd2: begin
                buf_next[15:8]  = rx_data;
                mask_next       = 4'b0001;
            end
            default: begin
                buf_next[7:0]   = rx_data;
                mask_next       = 4'b0000;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_HI;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and per-cycle action decode. A FIFO error outranks
    // everything; a byte arriving while a push is pending is an overrun.
    always_comb begin
        state_d   = state;
        take_byte = 1'b0;
        issue_wr  = 1'b0;
        issue_cmd = 1'b0;
        if (mem_wr_error && (state != DONE) && (state != ERROR)) begin
            state_d = ERROR;
        end else begin
            case (state)
                LEN_HI: begin
                    if (rx_valid) begin
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        state_d = ({len[15:8], rx_data} == 16'd0) ? DONE : DATA;
                    end
                end
                DATA: begin
                    // All bytes written: the last command pulse is on the
                    // outputs this cycle, so finishing now keeps DONE quiet.
                    if (k == len) begin
                        state_d = DONE;
                    end else if (rx_valid) begin
                        take_byte = 1'b1;
                        if (word_end) begin
                            state_d = PUSH_WR;
                        end
                    end
                end
                PUSH_WR: begin
                    if (rx_valid) begin
                        state_d = ERROR;
                    end else if (!mem_wr_full) begin
                        issue_wr = 1'b1;
                        state_d  = PUSH_CMD;
                    end
                end
                PUSH_CMD: begin
                    if (rx_valid) begin
                        state_d = ERROR;
                    end else if (!mem_cmd_full) begin
                        issue_cmd = 1'b1;
                        state_d   = DATA;
                    end
                end
                DONE:    state_d = DONE;
                ERROR:   state_d = ERROR;
                default: state_d = ERROR;
            endcase
        end
    end

    // Datapath: length capture, word assembly, counters and registered
    // memory-interface outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            len               <= 16'd0;
            k                 <= 16'd0;
            w                 <= 14'd0;
            word_buf          <= 32'd0;
            mem_cmd_en        <= 1'b0;
            mem_wr_en         <= 1'b0;
            mem_cmd_byte_addr <= BASE_ADDR;
            mem_wr_data       <= 32'd0;
            mem_wr_mask       <= 4'd0;
            boot_done         <= 1'b0;
            boot_error        <= 1'b0;
        end else begin
            mem_wr_en  <= issue_wr;
            mem_cmd_en <= issue_cmd;
            boot_done  <= (state_d == DONE);
            boot_error <= (state_d == ERROR);

            if ((state == LEN_HI) && (state_d == LEN_LO)) begin
                len[15:8] <= rx_data;
            end
            if ((state == LEN_LO) && (state_d != LEN_LO)) begin
                len[7:0] <= rx_data;
            end

            if (take_byte) begin
                k <= k_inc;
                if (word_end) begin
                    mem_wr_data <= buf_next;
                    mem_wr_mask <= (k[1:0] == 2'd3) ? 4'b0000 : mask_next;
                    word_buf    <= 32'd0;
                end else begin
                    word_buf <= buf_next;
                end
            end

            if (issue_wr) begin
                mem_cmd_byte_addr <= BASE_ADDR + {14'd0, w, 2'b00};
            end

            if (issue_cmd) begin
                w <= w + 14'd1;
            end
        end
    end

endmodule
